// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared encodings for the forwarding/hazard unit: stall causes, the
// stall-cause FSM states and the rule that sizes the forwarding select.
package core_hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_LU   = 2'b01,
    CAUSE_SB   = 2'b10,
    CAUSE_NRDY = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_LU   = 2'b01,
    ST_SBW  = 2'b10,
    ST_NRDY = 2'b11
  } state_e;

  // Smallest select width that encodes "register file" plus every stage.
  function automatic int sel_w_min(input int num_stg);
    return $clog2(num_stg + 1);
  endfunction

  // True when a select width can encode all producer stages.
  function automatic bit sel_w_ok(input int sel_w, input int num_stg);
    return (sel_w >= sel_w_min(num_stg));
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_if.sv
// Pipeline-side bundle of the forwarding/hazard unit. The master is the
// pipeline (drives operand/producer info), the slave is the hazard unit.
interface fwd_hazard_scoreboard_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 2,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [ADDR_W-1:0]         id_rd;
  logic                      id_regwrite;
  logic [NUM_SRC*ADDR_W-1:0] ex_rs;
  logic                      ex_memread;
  logic [ADDR_W-1:0]         ex_rd;
  logic [NUM_STG-1:0]        stg_regwrite;
  logic [NUM_STG*ADDR_W-1:0] stg_rd;
  logic [NUM_STG-1:0]        stg_ready;
  logic                      lat_issue;
  logic [ADDR_W-1:0]         lat_rd;
  logic                      lat_done;
  logic [ADDR_W-1:0]         lat_done_rd;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic                      bubble;
  logic [1:0]                stall_cause;
  logic [CNT_W-1:0]          stall_cnt;
  logic [(2**ADDR_W)-1:0]    sb_pending;
  logic                      sb_timeout;

  modport master (
    output id_rs, id_rs_used, id_rd, id_regwrite, ex_rs, ex_memread, ex_rd,
           stg_regwrite, stg_rd, stg_ready, lat_issue, lat_rd, lat_done,
           lat_done_rd, flush,
    input  fwd_sel, stall, bubble, stall_cause, stall_cnt, sb_pending, sb_timeout
  );

  modport slave (
    input  id_rs, id_rs_used, id_rd, id_regwrite, ex_rs, ex_memread, ex_rd,
           stg_regwrite, stg_rd, stg_ready, lat_issue, lat_rd, lat_done,
           lat_done_rd, flush,
    output fwd_sel, stall, bubble, stall_cause, stall_cnt, sb_pending, sb_timeout
  );
endinterface

// File: rtl/fwd_hazard_scoreboard_sb.sv
// Pending-result scoreboard for multi-cycle ops. Bits are set on issue and
// cleared on writeback; a same-cycle writeback hides the bit from readers.
module hazard_scoreboard
  import core_hazard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int NREGS   = 2**ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0] i_id_rs,
  input  logic [NUM_SRC-1:0]        i_id_rs_used,
  input  logic [ADDR_W-1:0]         i_id_rd,
  input  logic                      i_id_regwrite,
  input  logic                      i_lat_issue,
  input  logic [ADDR_W-1:0]         i_lat_rd,
  input  logic                      i_lat_done,
  input  logic [ADDR_W-1:0]         i_lat_done_rd,
  output logic [NREGS-1:0]          o_sb_pending,
  output logic                      o_sb_haz
);

  logic [NREGS-1:0]   r_pending;
  logic [NREGS-1:0]   w_pending_nxt;
  logic [NUM_SRC-1:0] w_rd_haz;
  logic               w_waw_haz;

  // Next scoreboard value: clear first so a same-register issue wins; x0 stays clear.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_lat_done) begin
      w_pending_nxt[i_lat_done_rd] = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
    if (i_lat_issue && (i_lat_rd != {ADDR_W{1'b0}})) begin
      w_pending_nxt[i_lat_rd] = 1'b1;
    end else begin
      w_pending_nxt[0] = 1'b0;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= {NREGS{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_rd
    logic [ADDR_W-1:0] w_rs;
    assign w_rs        = i_id_rs[p*ADDR_W +: ADDR_W];
    assign w_rd_haz[p] = i_id_rs_used[p] && (w_rs != {ADDR_W{1'b0}}) && r_pending[w_rs]
                         && !(i_lat_done && (i_lat_done_rd == w_rs));
  end

  assign w_waw_haz    = i_id_regwrite && r_pending[i_id_rd];
  assign o_sb_haz     = (|w_rd_haz) || w_waw_haz;
  assign o_sb_pending = r_pending;

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding select, load-use / not-ready / scoreboard stall
// generation, stall-cause FSM, saturating stall counter and SBW watchdog.
module fwd_hazard_scoreboard
  import core_hazard_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 2,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  fwd_hazard_scoreboard_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic [NUM_SRC-1:0]       w_nrdy_v;
  logic [NUM_SRC-1:0]       w_lu_v;
  logic                     w_sb_haz;
  cause_e                   w_cause;
  logic                     w_stall;
  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [WD_W-1:0]          r_wd;
  logic [WD_W-1:0]          w_wd_nxt;
  logic                     r_timeout;
  logic [CNT_W-1:0]         r_cnt;

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    logic [ADDR_W-1:0] w_ex_rs;
    logic [ADDR_W-1:0] w_id_rs;
    logic [SEL_W-1:0]  w_sel;
    logic              w_nrdy;
    logic              w_hit;
    assign w_ex_rs = bus.ex_rs[p*ADDR_W +: ADDR_W];
    assign w_id_rs = bus.id_rs[p*ADDR_W +: ADDR_W];

    // Scan oldest to youngest so the youngest matching producer is the one left selected.
    always_comb begin
      w_sel  = {SEL_W{1'b0}};
      w_nrdy = 1'b0;
      w_hit  = 1'b0;
      for (int k = NUM_STG - 1; k >= 0; k--) begin
        w_hit  = bus.stg_regwrite[k] && (bus.stg_rd[k*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})
                 && (bus.stg_rd[k*ADDR_W +: ADDR_W] == w_ex_rs);
        w_sel  = w_hit ? SEL_W'(k + 1) : w_sel;
        w_nrdy = w_hit ? !bus.stg_ready[k] : w_nrdy;
      end
    end

    assign w_fwd_sel[p*SEL_W +: SEL_W] = w_sel;
    assign w_nrdy_v[p] = w_nrdy;
    assign w_lu_v[p]   = bus.ex_memread && (bus.ex_rd != {ADDR_W{1'b0}}) && bus.id_rs_used[p]
                         && (w_id_rs == bus.ex_rd);
  end

  hazard_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_SRC (NUM_SRC)
  ) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_id_rs       (bus.id_rs),
    .i_id_rs_used  (bus.id_rs_used),
    .i_id_rd       (bus.id_rd),
    .i_id_regwrite (bus.id_regwrite),
    .i_lat_issue   (bus.lat_issue),
    .i_lat_rd      (bus.lat_rd),
    .i_lat_done    (bus.lat_done),
    .i_lat_done_rd (bus.lat_done_rd),
    .o_sb_pending  (bus.sb_pending),
    .o_sb_haz      (w_sb_haz)
  );

  // Prioritised stall cause (not-ready > load-use > scoreboard); flush drops the stall.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (bus.flush) begin
      w_cause = CAUSE_NONE;
    end else if (|w_nrdy_v) begin
      w_cause = CAUSE_NRDY;
    end else if (|w_lu_v) begin
      w_cause = CAUSE_LU;
    end else if (w_sb_haz) begin
      w_cause = CAUSE_SB;
    end else begin
      w_cause = CAUSE_NONE;
    end
  end

  assign w_stall = (w_cause != CAUSE_NONE);

  // FSM next state follows this cycle's stall cause; flush returns to RUN.
  always_comb begin
    w_state_nxt = ST_RUN;
    if (bus.flush) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (w_cause)
        CAUSE_LU:   w_state_nxt = ST_LU;
        CAUSE_SB:   w_state_nxt = ST_SBW;
        CAUSE_NRDY: w_state_nxt = ST_NRDY;
        default:    w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Watchdog: consecutive SBW cycles, restarting on entry and saturating at TIMEOUT.
  always_comb begin
    w_wd_nxt = {WD_W{1'b0}};
    if (w_state_nxt == ST_SBW) begin
      if (r_state != ST_SBW) begin
        w_wd_nxt = WD_W'(1);
      end else if (r_wd == WD_W'(TIMEOUT)) begin
        w_wd_nxt = r_wd;
      end else begin
        w_wd_nxt = r_wd + WD_W'(1);
      end
    end else begin
      w_wd_nxt = {WD_W{1'b0}};
    end
  end

  // State, watchdog, sticky timeout and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_wd      <= {WD_W{1'b0}};
      r_timeout <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_wd      <= w_wd_nxt;
      r_timeout <= r_timeout || (w_wd_nxt == WD_W'(TIMEOUT));
      if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign bus.fwd_sel     = w_fwd_sel;
  assign bus.stall       = w_stall;
  assign bus.bubble      = w_stall;
  assign bus.stall_cause = w_cause;
  assign bus.stall_cnt   = r_cnt;
  assign bus.sb_timeout  = r_timeout;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with default parameters.
// Each vector is applied 1 ns after a rising edge and checked 3 ns later,
// so every vector sees exactly one clock edge before the next one.
module tb_fwd_hazard_scoreboard;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  fwd_hazard_scoreboard_if #(.ADDR_W(5), .NUM_SRC(2), .NUM_STG(2), .SEL_W(2), .CNT_W(16)) bus ();

  fwd_hazard_scoreboard #(
    .ADDR_W(5), .NUM_SRC(2), .NUM_STG(2), .SEL_W(2), .TIMEOUT(64), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.id_rs        = 10'd0;
    bus.id_rs_used   = 2'b00;
    bus.id_rd        = 5'd0;
    bus.id_regwrite  = 1'b0;
    bus.ex_rs        = 10'd0;
    bus.ex_memread   = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.stg_regwrite = 2'b00;
    bus.stg_rd       = 10'd0;
    bus.stg_ready    = 2'b00;
    bus.lat_issue    = 1'b0;
    bus.lat_rd       = 5'd0;
    bus.lat_done     = 1'b0;
    bus.lat_done_rd  = 5'd0;
    bus.flush        = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string tag, input logic st, input logic [1:0] cause);
    chk({tag, "_stall"}, 64'(bus.stall), 64'(st));
    chk({tag, "_bubble"}, 64'(bus.bubble), 64'(st));
    chk({tag, "_cause"}, 64'(bus.stall_cause), 64'(cause));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr();
    #3;
    chk("rst_fwd", 64'(bus.fwd_sel), 64'd0);
    chk_stall("rst", 1'b0, 2'b00);
    chk("rst_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_pend", 64'(bus.sb_pending), 64'd0);
    chk("rst_to", 64'(bus.sb_timeout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nxt();

    // Both stages write x5: port0 takes the youngest, port1 reads x0
    bus.stg_regwrite = 2'b11; bus.stg_ready = 2'b11;
    bus.stg_rd = {5'd5, 5'd5}; bus.ex_rs = {5'd0, 5'd5};
    #3;
    chk("fwd_young", 64'(bus.fwd_sel), 64'h1);
    chk_stall("fwd_young", 1'b0, 2'b00);
    nxt();

    // Only WB writes x5, only EX/MEM writes x3
    bus.stg_rd = {5'd5, 5'd3}; bus.ex_rs = {5'd3, 5'd5};
    #3;
    chk("fwd_mix", 64'(bus.fwd_sel), 64'h6);
    nxt();

    // Younger match not ready: older ready match must not take over
    bus.stg_rd = {5'd5, 5'd5}; bus.stg_ready = 2'b10; bus.ex_rs = {5'd0, 5'd5};
    #3;
    chk("nrdy_fwd", 64'(bus.fwd_sel), 64'h1);
    chk_stall("nrdy", 1'b1, 2'b11);
    nxt();                                   // stall edge 1

    // Load-use: load to x7 in EX, ID reads x7
    clr();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd7;
    bus.id_rs = {5'd0, 5'd7}; bus.id_rs_used = 2'b01;
    #3;
    chk_stall("lu", 1'b1, 2'b01);
    nxt();                                   // stall edge 2

    // Load now in MEM, data not ready; consumer now in EX
    bus.ex_memread = 1'b0; bus.ex_rd = 5'd0; bus.ex_rs = {5'd0, 5'd7};
    bus.stg_regwrite = 2'b01; bus.stg_rd = {5'd0, 5'd7}; bus.stg_ready = 2'b00;
    #3;
    chk_stall("lu_mem", 1'b1, 2'b11);
    chk("lu_mem_fwd", 64'(bus.fwd_sel), 64'h1);
    nxt();                                   // stall edge 3

    // Load reaches WB with data: forward from WB
    bus.stg_regwrite = 2'b10; bus.stg_rd = {5'd7, 5'd0}; bus.stg_ready = 2'b10;
    #3;
    chk_stall("lu_wb", 1'b0, 2'b00);
    chk("lu_wb_fwd", 64'(bus.fwd_sel), 64'h2);
    nxt();

    // Multi-cycle issue to x9
    clr();
    bus.lat_issue = 1'b1; bus.lat_rd = 5'd9;
    #3;
    chk("sb_pre", 64'(bus.sb_pending), 64'd0);
    nxt();

    // Consumer of x9 on port1 stalls for 10 cycles
    bus.lat_issue = 1'b0; bus.lat_rd = 5'd0;
    bus.id_rs = {5'd9, 5'd0}; bus.id_rs_used = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk_stall("sb_wait", 1'b1, 2'b10);
      chk("sb_bit9", 64'(bus.sb_pending), 64'h200);
      nxt();                                 // stall edges 4..13
    end

    // Writeback of x9 this cycle releases the stall at once
    bus.lat_done = 1'b1; bus.lat_done_rd = 5'd9;
    #3;
    chk_stall("sb_done", 1'b0, 2'b00);
    nxt();

    // Same-cycle issue and done on x12: set wins
    clr();
    #3;
    chk("sb_clr9", 64'(bus.sb_pending), 64'd0);
    bus.lat_issue = 1'b1; bus.lat_rd = 5'd12;
    bus.lat_done = 1'b1; bus.lat_done_rd = 5'd12;
    nxt();

    // WAW on x12; also try to set x0
    clr();
    bus.id_regwrite = 1'b1; bus.id_rd = 5'd12;
    bus.lat_issue = 1'b1; bus.lat_rd = 5'd0;
    #3;
    chk("sb_set12", 64'(bus.sb_pending), 64'h1000);
    chk_stall("waw", 1'b1, 2'b10);
    nxt();                                   // stall edge 14

    // Flush during load-use (plus WAW) suppresses everything
    bus.lat_issue = 1'b0;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd7;
    bus.id_rs = {5'd0, 5'd7}; bus.id_rs_used = 2'b01;
    bus.flush = 1'b1;
    #3;
    chk("sb_x0", 64'(bus.sb_pending), 64'h1000);
    chk_stall("flush", 1'b0, 2'b00);
    nxt();

    // Without flush, load-use outranks scoreboard
    bus.flush = 1'b0;
    #3;
    chk_stall("lu_over_sb", 1'b1, 2'b01);
    chk("cnt14", 64'(bus.stall_cnt), 64'd14);
    nxt();                                   // stall edge 15

    // WAW-only stall, then async reset in the middle of the cycle
    clr();
    bus.id_regwrite = 1'b1; bus.id_rd = 5'd12;
    #3;
    chk_stall("pre_rst", 1'b1, 2'b10);
    chk("cnt15", 64'(bus.stall_cnt), 64'd15);
    #2;
    rst_n = 1'b0;
    #1;
    chk_stall("async_rst", 1'b0, 2'b00);
    chk("async_rst_pend", 64'(bus.sb_pending), 64'd0);
    chk("async_rst_cnt", 64'(bus.stall_cnt), 64'd0);
    clr();
    @(negedge clk);
    rst_n = 1'b1;
    nxt();

    // Watchdog: issue to x20, then hold a read of x20 for 64 cycles
    bus.lat_issue = 1'b1; bus.lat_rd = 5'd20;
    nxt();
    bus.lat_issue = 1'b0; bus.lat_rd = 5'd0;
    bus.id_rs = {5'd0, 5'd20}; bus.id_rs_used = 2'b01;
    for (int i = 0; i < 64; i++) begin
      #3;
      if (i == 0 || i == 63) begin
        chk_stall("wd_hold", 1'b1, 2'b10);
        chk("wd_to_low", 64'(bus.sb_timeout), 64'd0);
      end
      nxt();
    end
    #3;
    chk("wd_to_set", 64'(bus.sb_timeout), 64'd1);
    chk("wd_cnt64", 64'(bus.stall_cnt), 64'd64);
    clr();
    nxt();
    nxt();
    #3;
    chk_stall("wd_after", 1'b0, 2'b00);
    chk("wd_sticky", 64'(bus.sb_timeout), 64'd1);
    chk("wd_cnt_hold", 64'(bus.stall_cnt), 64'd64);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational forwarding logic.
- Selects bypass sources for NUM_SRC execute-stage operands across NUM_STG producer stages, youngest first.
- Detects load-use and not-yet-ready producer hazards.
- Keeps a per-register scoreboard for multi-cycle (mul/div) results, and generates stall/bubble with a cause FSM, a stall counter and a watchdog.
- Sits between the ID/EX pipeline registers and the hazard/PC-control logic of the core.

Parameters:
- ADDR_W, 5, register-address width; NREGS = 2**ADDR_W.
- NUM_SRC, 2, operand read ports per instruction (3 for fused ops).
- NUM_STG, 2, forwarding producer stages; index 0 = youngest (EX/MEM), NUM_STG-1 = oldest (WB).
- SEL_W, 2, fwd_sel field width; must satisfy 2**SEL_W > NUM_STG.
- TIMEOUT, 64, scoreboard-stall cycles before sb_timeout is raised.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  NUM_SRC*ADDR_W  decode-stage source registers, packed, port 0 in LSBs
- id_rs_used  in  NUM_SRC  per-port source-valid flags
- id_rd  in  ADDR_W  decode-stage destination register
- id_regwrite  in  1  decode instruction writes id_rd
- ex_rs  in  NUM_SRC*ADDR_W  execute-stage source registers, packed
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  ADDR_W  EX destination register
- stg_regwrite  in  NUM_STG  producer-stage write enables
- stg_rd  in  NUM_STG*ADDR_W  producer-stage destination registers
- stg_ready  in  NUM_STG  producer data valid in that stage (0 for a load still in MEM)
- lat_issue  in  1  multi-cycle op issued this cycle
- lat_rd  in  ADDR_W  its destination register
- lat_done  in  1  multi-cycle result written back this cycle
- lat_done_rd  in  ADDR_W  its destination register
- flush  in  1  branch/exception flush of IF/ID
- fwd_sel  out  NUM_SRC*SEL_W  per-port select: 0 = register file, k = stage k-1
- stall  out  1  hold PC and IF/ID
- bubble  out  1  insert NOP into ID/EX
- stall_cause  out  2  00 none, 01 load-use, 10 scoreboard, 11 producer not ready
- stall_cnt  out  CNT_W  saturating total stall cycles
- sb_pending  out  NREGS  scoreboard bits
- sb_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n low, async): sb_pending=0, FSM=RUN, stall_cnt=0, sb_timeout=0, watchdog=0. Outputs then settle to fwd_sel=0, stall=0, bubble=0, stall_cause=00.
- Forwarding (combinational, 0 latency), per port p:
  - Choose the lowest-index stage k with stg_regwrite[k], stg_rd[k]!=0 and stg_rd[k]==ex_rs[p]; fwd_sel=k+1.
  - If no stage matches, or ex_rs[p]==0, fwd_sel=0.
  - An older match never overrides a younger one, even if the younger stage is not ready.
- Hazard terms (combinational, evaluated on used ID ports only, rs!=0):
  - ready_haz: the selected youngest stage has stg_ready=0. Evaluate on EX ports.
  - lu_haz: ex_memread, ex_rd!=0, and ex_rd equals an ID source.
  - sb_haz: sb_pending[id_rs[p]] is set and not cleared this cycle (lat_done with matching lat_done_rd masks it), OR id_regwrite with sb_pending[id_rd] set (WAW).
- stall = lu_haz|sb_haz|ready_haz; bubble = stall.
- stall_cause priority: 11 > 01 > 10. Both outputs are suppressed (0) while flush=1.
- Scoreboard (registered, visible next cycle):
  - lat_issue with lat_rd!=0 sets the bit.
  - lat_done clears the bit.
  - Simultaneous issue and done on the same register: the set wins.
  - Register 0 is never set.
- FSM states RUN, LU, SBW, NRDY, registered each cycle from stall_cause. flush forces RUN.
- stall_cnt increments on every stall cycle and saturates at all-ones.
- Watchdog:
  - Counts consecutive cycles in SBW; clears on leaving SBW.
  - Reaching TIMEOUT sets sb_timeout, which stays set until reset.

Decomposition:
- Shared package core_hazard_pkg holds the stall_cause encodings, the FSM state enum, and the SEL_W width rule.
- Sub-module hazard_scoreboard contains sb_pending set/clear logic and the pending lookup with lat_done masking.
- The forwarding priority mux, FSM and counters stay in the top module.

Test Plan:
- NUM_STG=2: stg_rd={x5,x5}, both regwrite and ready, ex_rs0=x5 -> fwd_sel port0=1 (youngest); ex_rs1=x0 -> port1=0.
- ex_memread=1, ex_rd=x7, id_rs0=x7 used -> stall=1, bubble=1, stall_cause=01 for exactly one cycle; next cycle load in MEM with stg_ready[0]=0 -> cause 11; then forward from WB, fwd_sel=2.
- lat_issue rd=x9, then id_rs1=x9 for 10 cycles -> stall=1 with cause 10 each cycle; lat_done rd=x9 that cycle -> stall=0 the same cycle and sb_pending[9]=0 next cycle.
- lat_issue and lat_done both on x12 in the same cycle -> sb_pending[12]=1 next cycle; id_regwrite rd=x12 -> WAW stall.
- Hold scoreboard stall for 64 cycles -> sb_timeout=1 and stays 1 after the stall ends; stall_cnt=64.
- Assert rst_n=0 mid-stall with pending bits set -> all outputs and counters 0 immediately, asynchronously; flush=1 during lu_haz -> stall=0.
